macc_input_pacer: RTL and testbench

- Sits directly upstream of the single-MACC FIR filter.
- Accepts input samples from a bursty source, which may present one per clock, and buffers them in a small FIFO.
- Re-issues them as single-cycle new-data strobes spaced at least SPACING clocks apart, because the filter needs one clock per tap to process each sample.
- Reports FIFO level, full/empty and a sticky overflow flag for samples dropped while full.

---
 rtl/macc_input_pacer_if.sv | 28 ++
 rtl/macc_input_pacer.sv | 96 +++++++++
 tb/tb_macc_input_pacer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/macc_input_pacer_if.sv
// Sample bus between a bursty source, the pacer and the MACC FIR filter.
// Slave modport is the pacer's view; master is the source/sink view.
interface macc_input_pacer_if #(
  parameter int DATA_WIDTH = 18,
  parameter int FIFO_AW    = 4
);
  logic [DATA_WIDTH-1:0] Data_i;
  logic                  DataNd_i;
  logic                  ClearOvf_i;
  logic [DATA_WIDTH-1:0] Data_o;
  logic                  DataNd_o;
  logic [FIFO_AW:0]      Level_o;
  logic                  Empty_o;
  logic                  Full_o;
  logic                  Overflow_o;

  modport slave (
    input  Data_i, DataNd_i, ClearOvf_i,
    output Data_o, DataNd_o, Level_o,
    output Empty_o, Full_o, Overflow_o
  );

  modport master (
    output Data_i, DataNd_i, ClearOvf_i,
    input  Data_o, DataNd_o, Level_o,
    input  Empty_o, Full_o, Overflow_o
  );
endinterface

// File: rtl/macc_input_pacer.sv
// Buffers bursty input samples in a small FIFO and re-issues them as
// single-cycle strobes spaced at least SPACING clocks apart.
module macc_input_pacer #(
  parameter int DATA_WIDTH = 18,
  parameter int FIFO_AW    = 4,
  parameter int SPACING    = 16
) (
  input  logic Clk_i,
  input  logic Rst_i,
  macc_input_pacer_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [7:0] SP_RLD = 8'(SPACING - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      level_q, level_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  nd_q, nd_d;
  logic                  ovf_q, ovf_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // Pop uses registered state only, so a fresh sample never falls through.
  always_comb begin
    full     = (level_q == FULL_LVL);
    pop      = (level_q != '0) && (cnt_q == '0);
    push     = bus.DataNd_i && (!full || pop);
    drop     = bus.DataNd_i && !push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    nd_d     = 1'b0;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q];
      nd_d     = 1'b1;
      cnt_d    = SP_RLD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (drop) ovf_d = 1'b1;
    else if (bus.ClearOvf_i) ovf_d = 1'b0;
  end

  // Sample storage; a read of the slot being overwritten sees the old head.
  always_ff @(posedge Clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.Data_i;
  end

  // Control and output registers.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      nd_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      nd_q     <= nd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.Data_o     = data_q;
  assign bus.DataNd_o   = nd_q;
  assign bus.Level_o    = level_q;
  assign bus.Empty_o    = (level_q == '0);
  assign bus.Full_o     = full;
  assign bus.Overflow_o = ovf_q;

endmodule

// File: tb/tb_macc_input_pacer.sv
// Scoreboard bench for macc_input_pacer: expected samples queued on
// drive, compared as DataNd_o strobes appear.
module tb_macc_input_pacer;

  localparam int DW = 18;
  localparam int AW = 4;
  localparam int SP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  macc_input_pacer_if #(.DATA_WIDTH(DW), .FIFO_AW(AW)) bus ();

  macc_input_pacer #(
    .DATA_WIDTH(DW), .FIFO_AW(AW), .SPACING(SP)
  ) dut (
    .Clk_i(clk),
    .Rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int max_lvl = 0;
  int last_pulse = -1;
  int t0;
  logic [DW-1:0] exp_q [$];
  int pulse_q [$];
  int dq [$];
  int sine [8] = '{0, 707, 1000, 707, 0, -707, -1000, -707};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard compare, pulse timing log, level peak.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (int'(bus.Level_o) > max_lvl) max_lvl = int'(bus.Level_o);
      if (bus.DataNd_o) begin
        pulse_q.push_back(cyc);
        if (last_pulse >= 0)
          chk("gap", 32'((cyc - last_pulse) >= SP), 32'd1);
        last_pulse = cyc;
        if (exp_q.size() == 0) chk("unexp_pulse", 32'd1, 32'd0);
        else chk("data", 32'(bus.Data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drain();
    int n = 0;
    @(negedge clk);
    bus.DataNd_i = 1'b0;
    while ((exp_q.size() != 0 || !bus.Empty_o) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 600), 32'd1);
    repeat (SP + 2) @(negedge clk);
  endtask

  task automatic chk_pulses(input string tag, input int base, input int n);
    chk({tag, "_cnt"}, 32'(pulse_q.size()), 32'(n));
    for (int k = 0; k < n && k < pulse_q.size(); k++)
      chk({tag, "_t"}, 32'(pulse_q[k]), 32'(base + 2 + SP * k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.Data_i = '0;
    bus.DataNd_i = 1'b0;
    bus.ClearOvf_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(bus.Data_o), 32'd0);
    chk("rst_nd", 32'(bus.DataNd_o), 32'd0);
    chk("rst_lvl", 32'(bus.Level_o), 32'd0);
    chk("rst_empty", 32'(bus.Empty_o), 32'd1);
    chk("rst_full", 32'(bus.Full_o), 32'd0);
    chk("rst_ovf", 32'(bus.Overflow_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single sample
    pulse_q.delete();
    @(negedge clk);
    bus.Data_i = 18'h12345;
    bus.DataNd_i = 1'b1;
    exp_q.push_back(18'h12345);
    t0 = cyc;
    @(negedge clk);
    bus.DataNd_i = 1'b0;
    chk("s_lvl1", 32'(bus.Level_o), 32'd1);
    chk("s_nd0", 32'(bus.DataNd_o), 32'd0);
    @(negedge clk);
    chk("s_nd1", 32'(bus.DataNd_o), 32'd1);
    chk("s_data", 32'(bus.Data_o), 32'h12345);
    chk("s_lvl0", 32'(bus.Level_o), 32'd0);
    @(negedge clk);
    chk("s_nd_off", 32'(bus.DataNd_o), 32'd0);
    chk("s_hold", 32'(bus.Data_o), 32'h12345);
    drain();
    chk_pulses("single", t0, 1);

    // burst of 5
    pulse_q.delete();
    max_lvl = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.Data_i = DW'(i + 1);
      bus.DataNd_i = 1'b1;
      exp_q.push_back(DW'(i + 1));
      if (i == 0) t0 = cyc;
    end
    drain();
    chk_pulses("burst", t0, 5);
    chk("burst_peak", 32'(max_lvl), 32'd4);
    chk("burst_ovf", 32'(bus.Overflow_o), 32'd0);

    // overflow: 20 back-to-back into depth 16
    pulse_q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 17) begin
        chk("ov_lvl16", 32'(bus.Level_o), 32'd16);
        chk("ov_full", 32'(bus.Full_o), 32'd1);
      end
      if (i == 18) begin
        chk("ov_pushpop_lvl", 32'(bus.Level_o), 32'd16);
        chk("ov_not_yet", 32'(bus.Overflow_o), 32'd0);
      end
      if (i == 19) chk("ov_set", 32'(bus.Overflow_o), 32'd1);
      bus.Data_i = DW'(i + 1);
      bus.DataNd_i = 1'b1;
      if (i < 18) exp_q.push_back(DW'(i + 1));
      if (i == 0) t0 = cyc;
    end
    @(negedge clk);
    bus.DataNd_i = 1'b0;
    chk("ov_sticky", 32'(bus.Overflow_o), 32'd1);
    drain();
    chk_pulses("ov", t0, 18);

    // overflow clear, then clear coinciding with a drop
    @(negedge clk);
    bus.ClearOvf_i = 1'b1;
    @(negedge clk);
    bus.ClearOvf_i = 1'b0;
    chk("clr_nodrop", 32'(bus.Overflow_o), 32'd0);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus.Data_i = DW'(100 + i);
      bus.DataNd_i = 1'b1;
      bus.ClearOvf_i = (i == 18);
      if (i < 18) exp_q.push_back(DW'(100 + i));
    end
    @(negedge clk);
    bus.DataNd_i = 1'b0;
    bus.ClearOvf_i = 1'b0;
    chk("clr_vs_drop", 32'(bus.Overflow_o), 32'd1);
    @(negedge clk);
    bus.ClearOvf_i = 1'b1;
    @(negedge clk);
    bus.ClearOvf_i = 1'b0;
    chk("clr_again", 32'(bus.Overflow_o), 32'd0);
    drain();

    // asynchronous reset mid-burst
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.Data_i = DW'(200 + i);
      bus.DataNd_i = 1'b1;
      exp_q.push_back(DW'(200 + i));
    end
    @(negedge clk);
    bus.DataNd_i = 1'b0;
    chk("mr_lvl7", 32'(bus.Level_o), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_data", 32'(bus.Data_o), 32'd0);
    chk("mr_nd", 32'(bus.DataNd_o), 32'd0);
    chk("mr_lvl", 32'(bus.Level_o), 32'd0);
    chk("mr_empty", 32'(bus.Empty_o), 32'd1);
    exp_q.delete();
    pulse_q.delete();
    last_pulse = -1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("mr_silent", 32'(pulse_q.size()), 32'd0);
    chk("mr_empty2", 32'(bus.Empty_o), 32'd1);

    // steady cadence, one sample per SP clocks
    pulse_q.delete();
    max_lvl = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.Data_i = DW'(sine[k]);
      bus.DataNd_i = 1'b1;
      exp_q.push_back(DW'(sine[k]));
      dq.push_back(cyc);
      @(negedge clk);
      bus.DataNd_i = 1'b0;
      repeat (SP - 2) @(negedge clk);
    end
    drain();
    chk("cad_cnt", 32'(pulse_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < pulse_q.size(); k++)
      chk("cad_lat", 32'(pulse_q[k] - dq[k]), 32'd2);
    chk("cad_peak", 32'(max_lvl <= 1), 32'd1);
    chk("cad_ovf", 32'(bus.Overflow_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
